// File: rtl/alu_pkg.sv
// Shared definitions for the ALU round-robin arbiter: requester count,
// index width, FSM state encoding and the rotating priority search.
package alu_pkg;

  localparam int NREQ = 8;
  localparam int IDXW = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // First set request bit scanning ptr, ptr+1, ... with 3-bit wrap.
  // Returns 0 when no bit is set; callers only use it when req != 0.
  function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [IDXW-1:0] ptr);
    logic [IDXW-1:0] idx;
    logic            found;
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + IDXW'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/alu_rr_arbiter_decoder3_en.sv
// 3-to-8 one-hot decoder with enable; output is all-zero when disabled.
module decoder3_en
  import alu_pkg::*;
(
  input  logic            en,
  input  logic [IDXW-1:0] idx,
  output logic [NREQ-1:0] dec
);

  // One-hot decode of idx, gated by en.
  always_comb begin
    // NOTE: the default assignment first keeps this purely combinational; without it
    // the branch that skips the write would infer a latch.
    dec = '0;
    if (en) dec[idx] = 1'b1;
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing the single ALU between 8 requesters.
// A grant is held until the ALU reports completion, the owner withdraws its
// request, or the hold counter reaches HOLD_MAX. The counter restarts at 0 on
// each grant and the forced release happens at the edge that sees
// cnt==HOLD_MAX, so a grant that never completes stays valid for HOLD_MAX+1
// cycles. Every release passes through IDLE, so consecutive grants are always
// separated by at least one idle cycle.
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int HOLD_MAX = 15,
  parameter int CW       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            alu_done,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_vld,
  output logic            timeout
);

  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);

  state_t          state, state_nxt;
  logic [IDXW-1:0] ptr;
  logic [CW-1:0]   cnt;
  logic            any_req;
  logic            owner_req;
  logic            hold_hit;
  logic            release_now;
  logic            force_rel;

  assign any_req   = |req;
  assign owner_req = req[gnt_idx];
  assign hold_hit  = (cnt == HOLD_LIM);

  // Release causes; alu_done wins, so it never produces a timeout pulse.
  assign release_now = (state == BUSY) && (alu_done || !owner_req || hold_hit);
  assign force_rel   = (state == BUSY) && !alu_done && owner_req && hold_hit;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE -> BUSY on any request, BUSY -> IDLE on release.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)     state_nxt = BUSY;
      BUSY:    if (release_now) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: a grant is valid exactly while the FSM is BUSY.
  always_comb begin
    gnt_vld = (state == BUSY);
  end

  // Owner index, rotation pointer, hold counter and timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      gnt_idx <= '0;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= force_rel;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_idx <= rr_pick(req, ptr);
            cnt     <= '0;
          end
        end
        BUSY: begin
          if (release_now)       ptr <= gnt_idx + IDXW'(1);
          else if (!hold_hit)    cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // One-hot grant, forced to zero whenever no grant is active.
  decoder3_en u_dec (
    .en  (gnt_vld),
    .idx (gnt_idx),
    .dec (gnt)
  );

endmodule
